sdram_port_arbiter: RTL

// - Shares the single SDRAM port between the MTL display read path and the slideshow loader write path.
// - Display reads always have priority. Loader bursts are granted only in the vertical blanking window,

---
 rtl/sdram_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM port between the display read path (priority) and the loader
// write path (vertical blank only). Optional abort statistics under `ARB_STATS_EN.
module sdram_port_arbiter #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned GUARD = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iNewFrame,
  input  logic             iEndFrame,
  input  logic             iDISP_REQ,
  output logic             oDISP_GNT,
  input  logic             iLOAD_REQ,
  input  logic [LEN_W-1:0] iLOAD_LEN,
  input  logic             iLOAD_VALID,
  output logic             oLOAD_GNT,
  output logic             oLOAD_DONE,
  output logic             oLOAD_ABORT,
  output logic [LEN_W-1:0] oLOAD_LEFT,
  input  logic             iSDRAM_WAIT,
  output logic             oSDRAM_SEL,
  output logic             oSDRAM_RD,
  output logic             oSDRAM_WR,
  output logic [CNT_W-1:0] oABORT_CNT
);

  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {IDLE, DISP, LOAD, TURN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [GW-1:0]    turn_cnt, turn_cnt_nxt;
  logic             blank_q, blank_eff;
  logic             done_nxt, abort_nxt;
  logic [LEN_W-1:0] left_nxt;
  logic             beat_acc;

  // A same-cycle frame pulse takes effect immediately; new frame beats end frame.
  assign blank_eff = iNewFrame ? 1'b0 : (iEndFrame ? 1'b1 : blank_q);
  assign beat_acc  = (state == LOAD) & iLOAD_VALID & ~iSDRAM_WAIT;

  assign oDISP_GNT  = (state == DISP);
  assign oLOAD_GNT  = (state == LOAD);
  assign oSDRAM_SEL = (state == LOAD);
  assign oSDRAM_RD  = (state == DISP) & iDISP_REQ;
  assign oSDRAM_WR  = beat_acc;

  // Next-state and pulse generation.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    turn_cnt_nxt = turn_cnt;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    left_nxt     = oLOAD_LEFT;
    case (state)
      IDLE: begin
        if (iDISP_REQ) begin
          state_nxt = DISP;
        end else if (iLOAD_REQ && blank_eff && !oLOAD_DONE) begin
          // The !oLOAD_DONE term stops a zero-length request re-firing while its pulse is out.
          if (iLOAD_LEN != '0) begin
            state_nxt    = LOAD;
            beat_cnt_nxt = iLOAD_LEN;
            left_nxt     = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      DISP: begin
        if (!iDISP_REQ) state_nxt = IDLE;
      end
      LOAD: begin
        if (beat_acc && beat_cnt == LEN_W'(1)) begin
          done_nxt     = 1'b1;
          state_nxt    = TURN;
          turn_cnt_nxt = GW'(GUARD - 1);
          beat_cnt_nxt = '0;
        end else if (iNewFrame || iDISP_REQ) begin
          abort_nxt    = 1'b1;
          left_nxt     = beat_cnt - LEN_W'(beat_acc);
          state_nxt    = TURN;
          turn_cnt_nxt = GW'(GUARD - 1);
          beat_cnt_nxt = '0;
        end else if (beat_acc) begin
          beat_cnt_nxt = beat_cnt - LEN_W'(1);
        end
      end
      TURN: begin
        if (turn_cnt == '0) state_nxt = IDLE;
        else turn_cnt_nxt = turn_cnt - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      turn_cnt    <= '0;
      blank_q     <= 1'b1;
      oLOAD_DONE  <= 1'b0;
      oLOAD_ABORT <= 1'b0;
      oLOAD_LEFT  <= '0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      turn_cnt    <= turn_cnt_nxt;
      blank_q     <= blank_eff;
      oLOAD_DONE  <= done_nxt;
      oLOAD_ABORT <= abort_nxt;
      oLOAD_LEFT  <= left_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] abort_cnt;

  // Counts in step with the abort pulse and sticks at all-ones.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      abort_cnt <= '0;
    end else if (abort_nxt && abort_cnt != '1) begin
      abort_cnt <= abort_cnt + CNT_W'(1);
    end
  end

  assign oABORT_CNT = abort_cnt;
`else
  assign oABORT_CNT = '0;
`endif

endmodule
